rr_mux_arbiter: RTL

Round-robin arbiter that shares the 4:1 one-bit multiplexer between four requesters. It grants ownership to one requester at a time and drives the mux select with that requester's index. Each grant is held until the owner signals done, the owner drops its request, or a tenure timeout expires. It sits directly in front of the multiplexer and is the only driver of its sel input.

---
 rtl/rr_mux_arbiter_if.sv | 28 ++
 rtl/rr_mux_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter_if
// Description : Request/grant bundle between four requesters and the
//               round-robin arbiter that drives the shared mux select.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    logic       timeout_flag;

    // Requester side
    modport master (
        output req, done,
        input  gnt, sel, gnt_valid, timeout_flag
    );

    // Arbiter side
    modport slave (
        input  req, done,
        output gnt, sel, gnt_valid, timeout_flag
    );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Four-way round-robin arbiter with done/withdraw/timeout
//               release; sole driver of the 4:1 mux select.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic             gnt_valid_q;
    logic             tflag_q;
    logic [CNT_W-1:0] cnt_q;

    // Returns {found, index}; scan order ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] win;
    logic       rel_normal;
    logic       rel_tmo;

    // In GRANT ptr_q is the owner; in IDLE it is the last owner.
    assign win        = pick(bus.req, ptr_q);
    assign rel_normal = ~bus.req[ptr_q] | bus.done;
    assign rel_tmo    = (cnt_q == CNT_MAX) & ~rel_normal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            sel_q       <= 2'b00;
            ptr_q       <= 2'b11;
            gnt_valid_q <= 1'b0;
            tflag_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tflag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win[2]) begin
                        state_q     <= GRANT;
                        gnt_q       <= 4'b0001 << win[1:0];
                        sel_q       <= win[1:0];
                        ptr_q       <= win[1:0];
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                GRANT: begin
                    if (rel_normal || rel_tmo) begin
                        tflag_q <= rel_tmo;
                        cnt_q   <= '0;
                        if (win[2]) begin
                            gnt_q <= 4'b0001 << win[1:0];
                            sel_q <= win[1:0];
                            ptr_q <= win[1:0];
                        end else begin
                            // sel keeps the last owner so the mux output holds
                            state_q     <= IDLE;
                            gnt_q       <= 4'b0000;
                            gnt_valid_q <= 1'b0;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.sel          = sel_q;
    assign bus.gnt_valid    = gnt_valid_q;
    assign bus.timeout_flag = tflag_q;

endmodule
`default_nettype wire
